es_entrada_operandos: RTL

ES_ENTRADA_OPERANDOS -- requirements
Module: es_entrada_operandos

---
 rtl/es_entrada_operandos.sv | 107 ++++++++++
 1 files changed

// File: rtl/es_entrada_operandos.sv
// es_entrada_operandos: keypad entry of two decimal operands and a +/- operation
module es_entrada_operandos #(
  parameter int MAX_DIGITOS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tecla_valida,
  input  logic [3:0]  tecla,
  output logic [15:0] numero_1,
  output logic [15:0] numero_2,
  output logic [1:0]  suma_resta,
  output logic        operando_en,
  output logic        igual_en,
  output logic [15:0] entrada_actual
);
  typedef enum logic [1:0] {S_NUM1, S_NUM2, S_RESULTADO} estado_t;
  localparam logic [2:0] MAXD = 3'(MAX_DIGITOS);
  estado_t estado, estado_n;
  logic [15:0] n1_n, n2_n;
  logic [2:0] c1, c2, c1_n, c2_n;
  logic [1:0] sr_n;
  logic op_n;
  logic es_dig, es_op, es_ig, es_bo;
  assign es_dig = tecla_valida && tecla <= 4'd9;
  assign es_op  = tecla_valida && (tecla == 4'hA || tecla == 4'hB);
  assign es_ig  = tecla_valida && tecla == 4'hC;
  assign es_bo  = tecla_valida && tecla == 4'hD;
  // next state, operands and operation from the key just received
  always_comb begin
    estado_n = estado;
    n1_n = numero_1;
    n2_n = numero_2;
    c1_n = c1;
    c2_n = c2;
    sr_n = suma_resta;
    op_n = 1'b0;
    if (es_bo) begin
      estado_n = S_NUM1;
      n1_n = '0;
      n2_n = '0;
      c1_n = '0;
      c2_n = '0;
      sr_n = 2'd0;
    end else begin
      case (estado)
        S_NUM1: begin
          if (es_dig && c1 != MAXD) begin
            n1_n = numero_1 * 16'd10 + {12'd0, tecla};
            c1_n = c1 + 3'd1;
          end
          if (es_op) begin
            sr_n = tecla == 4'hA ? 2'd1 : 2'd2;
            op_n = 1'b1;
            n2_n = '0;
            c2_n = '0;
            estado_n = S_NUM2;
          end
        end
        S_NUM2: begin
          if (es_dig && c2 != MAXD) begin
            n2_n = numero_2 * 16'd10 + {12'd0, tecla};
            c2_n = c2 + 3'd1;
          end
          if (es_op) begin
            sr_n = tecla == 4'hA ? 2'd1 : 2'd2;
            op_n = 1'b1;
          end
          if (es_ig && c2 != 3'd0) estado_n = S_RESULTADO;
        end
        default: begin
          if (es_dig) begin
            n1_n = {12'd0, tecla};
            c1_n = 3'd1;
            n2_n = '0;
            c2_n = '0;
            sr_n = 2'd0;
            estado_n = S_NUM1;
          end
        end
      endcase
    end
  end
  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado <= S_NUM1;
      numero_1 <= '0;
      numero_2 <= '0;
      c1 <= '0;
      c2 <= '0;
      suma_resta <= 2'd0;
      operando_en <= 1'b0;
      igual_en <= 1'b0;
    end else begin
      estado <= estado_n;
      numero_1 <= n1_n;
      numero_2 <= n2_n;
      c1 <= c1_n;
      c2 <= c2_n;
      suma_resta <= sr_n;
      operando_en <= op_n;
      igual_en <= estado_n == S_RESULTADO;
    end
  end
  // operand under edit for the display
  always_comb entrada_actual = estado == S_NUM1 ? numero_1 : estado == S_NUM2 ? numero_2 : 16'd0;
endmodule
